debug_tx_sequencer: RTL and testbench

DEBUG_TX_SEQUENCER -- requirements
Module: debug_tx_sequencer

---
 rtl/debug_tx_sequencer_if.sv | 19 +
 rtl/debug_tx_sequencer.sv | 111 +++++++++++
 tb/tb_debug_tx_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_tx_sequencer_if.sv
// Write-side link between the debug frame sequencer and the UART transmit FIFO.
// The master presents bytes with a one-cycle strobe; the slave reports when it is full.
interface debug_tx_sequencer_if;
    logic [7:0] w_data;
    logic       wr_uart;
    logic       tx_full;

    modport master (
        output w_data,
        output wr_uart,
        input  tx_full
    );

    modport slave (
        input  w_data,
        input  wr_uart,
        output tx_full
    );
endinterface

// File: rtl/debug_tx_sequencer.sv
// Serialises a captured pipeline debug snapshot into the UART transmit FIFO as
// one start-of-frame byte followed by NUM_BYTES payload bytes, lowest byte first.
module debug_tx_sequencer #(
    parameter int         NUM_BYTES = 220,
    parameter logic [7:0] SOF_BYTE  = 8'hA5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   send_signal,
    input  logic [8*NUM_BYTES-1:0] snapshot,
    debug_tx_sequencer_if.master   tx,
    output logic                   data_sent,
    output logic                   busy
);
    localparam int               CNT_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SOF     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_DONE    = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t                 state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [7:0]             w_data_reg;
    logic                   wr_uart_reg;
    logic                   data_sent_reg;
    logic [8*NUM_BYTES-1:0] frame_reg;
    logic [7:0]             frame_bytes [NUM_BYTES];
    logic [7:0]             cur_byte;
    logic                   capture;

    assign capture = (state_reg == ST_IDLE) && send_signal;

    // Frame contents are frozen at request time so a live snapshot cannot tear a frame.
    always_ff @(posedge clock) begin
        if (capture) begin
            frame_reg <= snapshot;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_frame_bytes
            assign frame_bytes[gi] = frame_reg[8*gi +: 8];
        end
    endgenerate

    assign cur_byte = frame_bytes[cnt_reg];

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            w_data_reg    <= 8'h00;
            wr_uart_reg   <= 1'b0;
            data_sent_reg <= 1'b0;
        end else begin
            wr_uart_reg   <= 1'b0;
            data_sent_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (send_signal) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_SOF;
                    end
                end
                ST_SOF: begin
                    if (!tx.tx_full) begin
                        w_data_reg  <= SOF_BYTE;
                        wr_uart_reg <= 1'b1;
                        state_reg   <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    // The counter parks on the last index rather than wrapping.
                    if (!tx.tx_full) begin
                        w_data_reg  <= cur_byte;
                        wr_uart_reg <= 1'b1;
                        if (cnt_reg == LAST_IDX) begin
                            state_reg <= ST_DONE;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    data_sent_reg <= 1'b1;
                    state_reg     <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    // Wait for the request level to drop so one request yields one frame.
                    if (!send_signal) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx.w_data  = w_data_reg;
    assign tx.wr_uart = wr_uart_reg;
    assign data_sent  = data_sent_reg;
    assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_debug_tx_sequencer.sv
// Scoreboard bench: stimulus queues the expected write/done stream per instance,
// a negedge monitor pops and compares every write strobe and data_sent pulse.
module tb_debug_tx_sequencer;
    localparam int         NB_A      = 4;
    localparam int         NB_B      = 220;
    localparam logic [8:0] DONE_MARK = 9'h100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              a_send;
    logic              b_send;
    logic [8*NB_A-1:0] a_snap;
    logic [8*NB_B-1:0] b_snap;
    logic              a_ds;
    logic              a_busy;
    logic              b_ds;
    logic              b_busy;

    debug_tx_sequencer_if if_a ();
    debug_tx_sequencer_if if_b ();

    debug_tx_sequencer #(.NUM_BYTES(NB_A), .SOF_BYTE(8'hA5)) dut_a (
        .clock       (clk),
        .reset       (reset),
        .send_signal (a_send),
        .snapshot    (a_snap),
        .tx          (if_a),
        .data_sent   (a_ds),
        .busy        (a_busy)
    );

    debug_tx_sequencer dut_b (
        .clock       (clk),
        .reset       (reset),
        .send_signal (b_send),
        .snapshot    (b_snap),
        .tx          (if_b),
        .data_sent   (b_ds),
        .busy        (b_busy)
    );

    int         n_cmp;
    int         n_fail;
    int         a_writes;
    int         b_writes;
    int         b_dones;
    int         lat;
    logic [8:0] qa [$];
    logic [8:0] qb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (if_a.wr_uart === 1'b1) begin
                a_writes++;
                n_cmp++;
                if (qa.size() == 0) begin
                    n_fail++;
                    $display("FAIL a_write: got byte %02h, expected no write", if_a.w_data);
                end else begin
                    e = qa.pop_front();
                    if (e !== {1'b0, if_a.w_data}) begin
                        n_fail++;
                        $display("FAIL a_write: got byte %02h, expected %03h", if_a.w_data, e);
                    end
                end
            end
            if (a_ds === 1'b1) begin
                n_cmp++;
                if (qa.size() == 0) begin
                    n_fail++;
                    $display("FAIL a_done: got data_sent, expected none");
                end else begin
                    e = qa.pop_front();
                    if (e !== DONE_MARK) begin
                        n_fail++;
                        $display("FAIL a_done: got data_sent, expected %03h", e);
                    end
                end
            end
            if (if_b.wr_uart === 1'b1) begin
                b_writes++;
                n_cmp++;
                if (qb.size() == 0) begin
                    n_fail++;
                    $display("FAIL b_write: got byte %02h, expected no write", if_b.w_data);
                end else begin
                    e = qb.pop_front();
                    if (e !== {1'b0, if_b.w_data}) begin
                        n_fail++;
                        $display("FAIL b_write #%0d: got byte %02h, expected %03h", b_writes, if_b.w_data, e);
                    end
                end
            end
            if (b_ds === 1'b1) begin
                b_dones++;
                n_cmp++;
                if (qb.size() == 0) begin
                    n_fail++;
                    $display("FAIL b_done: got data_sent, expected none");
                end else begin
                    e = qb.pop_front();
                    if (e !== DONE_MARK) begin
                        n_fail++;
                        $display("FAIL b_done: got data_sent, expected %03h", e);
                    end
                end
            end
        end
    endtask

    task automatic push_a_frame(input logic [31:0] bytes);
        qa.push_back(9'h0A5);
        for (int k = 0; k < NB_A; k++) qa.push_back({1'b0, bytes[8*k +: 8]});
        qa.push_back(DONE_MARK);
    endtask

    task automatic wait_a_done(output int cycles);
        cycles = 0;
        while (a_ds !== 1'b1 && cycles < 100) begin
            step();
            cycles++;
        end
    endtask

    initial begin
        reset       = 1'b0;
        a_send      = 1'b0;
        b_send      = 1'b0;
        if_a.tx_full = 1'b0;
        if_b.tx_full = 1'b0;
        a_snap      = 32'h44332211;
        for (int k = 0; k < NB_B; k++) b_snap[8*k +: 8] = 8'((k * 7 + 3) ^ (k >> 3));
        n_cmp = 0; n_fail = 0; a_writes = 0; b_writes = 0; b_dones = 0;

        fork
            monitor();
        join_none

        // Reset state
        step(); step();
        chk("a_reset_wdata", if_a.w_data, 8'h00);
        chk("a_reset_wr", if_a.wr_uart, 0);
        chk("a_reset_ds", a_ds, 0);
        chk("a_reset_busy", a_busy, 0);
        chk("b_reset_wr", if_b.wr_uart, 0);
        chk("b_reset_busy", b_busy, 0);
        reset = 1'b1;
        step();

        // Plain frame, then request held high in RELEASE
        $display("txn 1: plain frame 44332211, request held 10 cycles after done");
        push_a_frame(32'h44332211);
        a_send = 1'b1;
        wait_a_done(lat);
        chk("a_latency_plain", lat, 7);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("a_release_busy", a_busy, 1);
            chk("a_release_no_wr", if_a.wr_uart, 0);
        end
        a_send = 1'b0;
        step();
        chk("a_release_to_idle", a_busy, 0);

        // Back-pressure after byte 22, request dropped mid-frame
        $display("txn 2: tx_full for 3 cycles after byte 22, request dropped in payload");
        push_a_frame(32'h44332211);
        a_send = 1'b1;
        step(); step();
        a_send = 1'b0;
        step(); step();
        chk("a_stall_entry_wdata", if_a.w_data, 8'h22);
        chk("a_stall_entry_wr", if_a.wr_uart, 1);
        if_a.tx_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("a_stall_wr", if_a.wr_uart, 0);
            chk("a_stall_wdata_hold", if_a.w_data, 8'h22);
            chk("a_stall_busy", a_busy, 1);
        end
        if_a.tx_full = 1'b0;
        wait_a_done(lat);
        chk("a_latency_after_stall", lat, 3);
        step();
        chk("a_release_immediate", a_busy, 0);

        // Snapshot changes right after capture
        $display("txn 3: snapshot overwritten one cycle after capture");
        push_a_frame(32'h44332211);
        a_send = 1'b1;
        step();
        a_snap = 32'hFFFFFFFF;
        wait_a_done(lat);
        chk("a_latency_snapchange", lat, 6);
        a_send = 1'b0;
        step();
        a_snap = 32'h44332211;

        // Reset after second payload byte
        $display("txn 4: reset after byte 22, then a fresh frame");
        push_a_frame(32'h44332211);
        a_send = 1'b1;
        step(); step(); step(); step();
        chk("a_pre_abort_wdata", if_a.w_data, 8'h22);
        reset  = 1'b0;
        a_send = 1'b0;
        step();
        chk("a_abort_wdata", if_a.w_data, 8'h00);
        chk("a_abort_wr", if_a.wr_uart, 0);
        chk("a_abort_ds", a_ds, 0);
        chk("a_abort_busy", a_busy, 0);
        chk("a_abort_pending", qa.size(), 3);
        qa.delete();
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step();
        push_a_frame(32'h44332211);
        a_send = 1'b1;
        wait_a_done(lat);
        chk("a_latency_after_reset", lat, 7);
        a_send = 1'b0;
        step();
        chk("a_idle_after_reset_frame", a_busy, 0);

        // Full-size frame with random back-pressure
        $display("txn 5: 220-byte frame with random tx_full");
        b_writes = 0;
        b_dones  = 0;
        qb.push_back(9'h0A5);
        for (int k = 0; k < NB_B; k++) qb.push_back({1'b0, 8'((k * 7 + 3) ^ (k >> 3))});
        qb.push_back(DONE_MARK);
        b_send = 1'b1;
        lat = 0;
        while (b_ds !== 1'b1 && lat < 3000) begin
            if_b.tx_full = 1'($urandom_range(0, 1));
            step();
            lat++;
        end
        chk("b_done_seen", b_ds, 1);
        if_b.tx_full = 1'b0;
        b_send = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("b_write_count", b_writes, NB_B + 1);
        chk("b_done_count", b_dones, 1);
        chk("b_idle_at_end", b_busy, 0);

        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
